cart_mbc1_responder: RTL and testbench
======================================

// Module: cart_mbc1_responder
// PURPOSE
// Cartridge-side end of the Game Boy cartridge bus. Decodes the CPU's a/dout/wr/rd/cs strobes
// as an MBC1 mapper: ROM/RAM bank registers, RAM enable, banking mode. Translates each access
// into one request on a req/ack external memory port (flash/PSRAM controller) and returns read
// data on the bus. Sits outside the gameboy top: drives its din, consumes a/dout/wr/rd/cs.
// PARAMETERS
// ROM_AW    21        ROM address bits (2 MiB max, 128 banks of 16 KiB)
// RAM_AW    15        cart RAM address bits (32 KiB, 4 banks of 8 KiB)
// MEM_AW    22        external memory address width
// RAM_BASE  22'h200000  external address where cart RAM image starts
// PORTS
// clk        in   1       4.19 MHz system clock (same clk as gameboy)
// rst        in   1       async reset, active-high
// gb_a       in   16      cartridge address bus
// gb_wdata   in   8       write data from CPU (gameboy dout)
// gb_wr      in   1       write strobe, level
// gb_rd      in   1       read strobe, level
// gb_cs      in   1       cart RAM chip select (A000-BFFF window)
// gb_rdata   out  8       read data to gameboy din
// busy       out  1       external access in flight
// mem_req    out  1       request to external memory, held until mem_ack
// mem_we     out  1       1 = write, 0 = read; valid while mem_req
// mem_addr   out  MEM_AW  external byte address; valid while mem_req
// mem_wdata  out  8       write data; valid while mem_req
// mem_ack    in   1       one-cycle completion pulse; mem_rdata valid same cycle
// mem_rdata  in   8       read data from external memory
// BEHAVIOUR
// Reset (async): ram_en=0, bank5=0, bank2=0, mode=0, FSM=IDLE, mem_req=0, mem_we=0,
//   mem_addr=0, mem_wdata=0, gb_rdata=8'hFF, busy=0, pending=0, last-access tag cleared.
// Access start: registered sample of {gb_a,gb_rd,gb_wr,gb_cs}; new access when (rd|wr) is high
//   and sample differs from previous cycle's (rising strobe or address change under rd).
// Register writes (wr start, a<8000) commit on the start cycle, no memory request:
//   0000-1FFF ram_en = (wdata[3:0]==4'hA); 2000-3FFF bank5 = wdata[4:0];
//   4000-5FFF bank2 = wdata[1:0]; 6000-7FFF mode = wdata[0].
// Effective bank5: 5'd0 maps to 5'd1 (so 0x20/0x40/0x60 select 0x21/0x41/0x61).
// ROM read 0000-3FFF: bank = mode ? {bank2,5'b0} : 0. 4000-7FFF: bank = {bank2,bank5eff}.
//   mem_addr = {bank,a[13:0]} truncated to ROM_AW, zero-extended to MEM_AW.
// RAM (A000-BFFF and gb_cs): rbank = mode ? bank2 : 0; mem_addr = RAM_BASE + {rbank,a[12:0]}
//   masked to RAM_AW. ram_en=0: reads return 8'hFF with no request; writes dropped.
// Addresses outside 0000-7FFF/A000-BFFF: ignored, gb_rdata unchanged, no request.
// FSM: IDLE -> RD (mem_req=1,we=0) or WR (mem_req=1,we=1) one cycle after access start.
//   RD/WR hold req/addr/data stable until mem_ack; on ack: RD latches gb_rdata<=mem_rdata,
//   req drops same edge, -> IDLE (or directly to next state if pending set).
// Latency: read data visible on gb_rdata the cycle after mem_ack; min 2 cycles from rd start.
// gb_rdata holds last read value between reads.
// Busy overlap: new memory access while RD/WR -> captured in one-deep pending slot (later
//   overwrites earlier); register writes still commit immediately. busy = req | pending.
// Simultaneous rd & wr high: treat as write. Bank change during RD: in-flight addr unchanged.
// Reset mid-access: req drops asynchronously; controller must tolerate abandoned request.
// STRUCTURE
// cart.vh: MBC1 address-window constants, FSM state encodings, RAM_ENABLE_KEY 4'hA.
// Sub-module mbc1_regs: bank/mode/ram_en registers plus combinational address translation;
//   top holds access detect, pending slot, FSM and memory-port registers.
// TESTING
// Reset, rd a=0150, ack after 3 cycles with 8'h3E -> mem_addr=0x000150, gb_rdata=8'h3E.
// wr 2000<=00, rd 4000 -> mem_addr=0x004000 (bank1); wr 2000<=1F,4000<=03 -> 0x1FC000.
// wr 6000<=01, 4000<=02, rd 0010 -> mem_addr=0x100010; mode 0 -> 0x000010.
// rd A123 cs=1 with ram_en=0 -> gb_rdata=8'hFF, no mem_req; wr 0000<=0A, wr A123<=55,
//   bank2=1 mode=1 -> mem_we=1, mem_addr=0x202123, mem_wdata=8'h55.
// Second rd during unacked RD -> pending, issued cycle after first ack; busy high throughout.
// Assert rst while mem_req=1 -> mem_req=0, gb_rdata=8'hFF, banks cleared immediately.

Source files
------------

// File: rtl/cart_mbc1_responder_pkg.sv
// Shared constants for the MBC1 cartridge responder: bus windows, the RAM
// enable key, controller state encodings and window-decode helpers.
package cart_mbc1_responder_pkg;

    localparam int ROM_AW_DEF = 21;
    localparam int RAM_AW_DEF = 15;
    localparam int MEM_AW_DEF = 22;

    localparam logic [15:0] ROM_LAST  = 16'h7FFF;
    localparam logic [15:0] RAM_FIRST = 16'hA000;
    localparam logic [15:0] RAM_LAST  = 16'hBFFF;

    localparam logic [3:0] RAM_ENABLE_KEY = 4'hA;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    // Register select is a[14:13] inside the 0000-7FFF window.
    typedef enum logic [1:0] {
        REG_RAM_EN = 2'd0,
        REG_BANK5  = 2'd1,
        REG_BANK2  = 2'd2,
        REG_MODE   = 2'd3
    } mbc_reg_t;

    function automatic logic in_rom_window(input logic [15:0] a);
        return (a <= ROM_LAST);
    endfunction

    function automatic logic in_ram_window(input logic [15:0] a);
        return (a >= RAM_FIRST) && (a <= RAM_LAST);
    endfunction

endpackage

// File: rtl/cart_mbc1_responder_regs.sv
// MBC1 mapper registers (RAM enable, 5-bit and 2-bit bank, banking mode)
// and the combinational translation of a CPU address into ROM/RAM image
// addresses on the external memory.
module cart_mbc1_responder_regs
    import cart_mbc1_responder_pkg::*;
#(
    parameter int                ROM_AW   = ROM_AW_DEF,
    parameter int                RAM_AW   = RAM_AW_DEF,
    parameter int                MEM_AW   = MEM_AW_DEF,
    parameter logic [MEM_AW-1:0] RAM_BASE = MEM_AW'(22'h200000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_we,
    input  logic [14:0]       reg_a,
    input  logic [4:0]        reg_wdata,
    output logic              ram_en,
    output logic [MEM_AW-1:0] rom_addr,
    output logic [MEM_AW-1:0] ram_addr
);

    localparam logic [MEM_AW-1:0] ROM_MASK = MEM_AW'((64'd1 << ROM_AW) - 64'd1);
    localparam logic [MEM_AW-1:0] RAM_MASK = MEM_AW'((64'd1 << RAM_AW) - 64'd1);

    logic [4:0] bank5;
    logic [1:0] bank2;
    logic       mode;
    logic [4:0] bank5_eff;
    logic [6:0] rom_bank;
    logic [1:0] ram_bank;

    // Register writes land on the access-start edge, selected by a[14:13].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_en <= 1'b0;
            bank5  <= 5'd0;
            bank2  <= 2'd0;
            mode   <= 1'b0;
        end else if (reg_we) begin
            case (mbc_reg_t'(reg_a[14:13]))
                REG_RAM_EN: ram_en <= (reg_wdata[3:0] == RAM_ENABLE_KEY);
                REG_BANK5:  bank5  <= reg_wdata[4:0];
                REG_BANK2:  bank2  <= reg_wdata[1:0];
                REG_MODE:   mode   <= reg_wdata[0];
                default:    ;
            endcase
        end
    end

    // Bank selection and address formation; bank 0 in the switchable window
    // is remapped to 1, which also turns 0x20/0x40/0x60 into 0x21/0x41/0x61.
    always_comb begin
        bank5_eff = (bank5 == 5'd0) ? 5'd1 : bank5;
        if (reg_a[14])
            rom_bank = {bank2, bank5_eff};
        else
            rom_bank = mode ? {bank2, 5'b0} : 7'd0;
        ram_bank = mode ? bank2 : 2'd0;
        rom_addr = MEM_AW'({rom_bank, reg_a[13:0]}) & ROM_MASK;
        ram_addr = RAM_BASE + (MEM_AW'({ram_bank, reg_a[12:0]}) & RAM_MASK);
    end

endmodule

// File: rtl/cart_mbc1_responder.sv
// Cartridge side of the Game Boy bus: detects CPU accesses, updates the MBC1
// registers, and turns ROM/RAM accesses into req/ack external memory cycles.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no external access outstanding
// ST_RD   | read request held on the memory port, waiting for mem_ack
// ST_WR   | write request held on the memory port, waiting for mem_ack
module cart_mbc1_responder
    import cart_mbc1_responder_pkg::*;
#(
    parameter int                ROM_AW   = ROM_AW_DEF,
    parameter int                RAM_AW   = RAM_AW_DEF,
    parameter int                MEM_AW   = MEM_AW_DEF,
    parameter logic [MEM_AW-1:0] RAM_BASE = MEM_AW'(22'h200000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       gb_a,
    input  logic [7:0]        gb_wdata,
    input  logic              gb_wr,
    input  logic              gb_rd,
    input  logic              gb_cs,
    output logic [7:0]        gb_rdata,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata
);

    logic [1:0]        state;
    logic [18:0]       sample_q;
    logic [18:0]       sample_d;
    logic              acc_start;
    logic              is_write;
    logic              rom_hit;
    logic              ram_hit;
    logic              reg_we;
    logic              ram_en;
    logic [MEM_AW-1:0] rom_addr;
    logic [MEM_AW-1:0] ram_addr;

    logic              new_mem;
    logic [MEM_AW-1:0] new_addr;
    logic              ff_read;

    logic              pend_valid;
    logic              pend_we;
    logic [MEM_AW-1:0] pend_addr;
    logic [7:0]        pend_wdata;

    logic              ack_now;
    logic              use_pend;
    logic              issue;
    logic              capture;
    logic              iss_we;
    logic [MEM_AW-1:0] iss_addr;
    logic [7:0]        iss_wdata;

    assign sample_d = {gb_a, gb_rd, gb_wr, gb_cs};

    cart_mbc1_responder_regs #(
        .ROM_AW   (ROM_AW),
        .RAM_AW   (RAM_AW),
        .MEM_AW   (MEM_AW),
        .RAM_BASE (RAM_BASE)
    ) u_regs (
        .clk       (clk),
        .rst       (rst),
        .reg_we    (reg_we),
        .reg_a     (gb_a[14:0]),
        .reg_wdata (gb_wdata[4:0]),
        .ram_en    (ram_en),
        .rom_addr  (rom_addr),
        .ram_addr  (ram_addr)
    );

    // Previous-cycle bus snapshot; any change while a strobe is up is a new access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sample_q <= '0;
        else
            sample_q <= sample_d;
    end

    // Access classification and issue/pending arbitration for this cycle.
    always_comb begin
        acc_start = (gb_rd | gb_wr) && (sample_d != sample_q);
        is_write  = gb_wr;
        rom_hit   = in_rom_window(gb_a);
        ram_hit   = in_ram_window(gb_a) && gb_cs;
        reg_we    = acc_start && is_write && rom_hit;
        new_mem   = acc_start && ((rom_hit && !is_write) || (ram_hit && ram_en));
        ff_read   = acc_start && !is_write && ram_hit && !ram_en;
        new_addr  = rom_hit ? rom_addr : ram_addr;

        ack_now   = (state != ST_IDLE) && mem_ack;
        use_pend  = ack_now && pend_valid;
        issue     = ((state == ST_IDLE) || ack_now) && (use_pend || new_mem);
        // A fresh access waits in the slot unless the port is free with nothing queued.
        capture   = new_mem && (((state != ST_IDLE) && !ack_now) || use_pend);
        iss_we    = use_pend ? pend_we    : is_write;
        iss_addr  = use_pend ? pend_addr  : new_addr;
        iss_wdata = use_pend ? pend_wdata : gb_wdata;
    end

    // One-deep pending slot; a later access overwrites an earlier one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_we    <= 1'b0;
            pend_addr  <= '0;
            pend_wdata <= 8'h00;
        end else if (capture) begin
            pend_valid <= 1'b1;
            pend_we    <= is_write;
            pend_addr  <= new_addr;
            pend_wdata <= gb_wdata;
        end else if (use_pend) begin
            pend_valid <= 1'b0;
        end
    end

    // Request FSM and memory-port registers; port fields only move on issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
        end else if (issue) begin
            state     <= iss_we ? ST_WR : ST_RD;
            mem_req   <= 1'b1;
            mem_we    <= iss_we;
            mem_addr  <= iss_addr;
            mem_wdata <= iss_wdata;
        end else if (ack_now) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
        end
    end

    // Read data back to the CPU; a disabled-RAM read is newer than any ack this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gb_rdata <= 8'hFF;
        end else begin
            if (ack_now && (state == ST_RD))
                gb_rdata <= mem_rdata;
            if (ff_read)
                gb_rdata <= 8'hFF;
        end
    end

    assign busy = mem_req | pend_valid;

endmodule

// File: tb/tb_cart_mbc1_responder.sv
// Directed bench for cart_mbc1_responder: a table of single accesses with
// hand-computed addresses/data, plus sequences for overlap, bank change
// mid-read and reset mid-access.
module tb_cart_mbc1_responder;

    localparam logic [1:0] OP_REG = 2'd0;
    localparam logic [1:0] OP_RD  = 2'd1;
    localparam logic [1:0] OP_WR  = 2'd2;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [7:0]  d;
        logic        cs;
        logic        exp_req;
        logic [21:0] exp_addr;
        logic [7:0]  exp_rdata;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] gb_a;
    logic [7:0]  gb_wdata;
    logic        gb_wr;
    logic        gb_rd;
    logic        gb_cs;
    logic [7:0]  gb_rdata;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [21:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[$];

    cart_mbc1_responder dut (
        .clk       (clk),
        .rst       (rst),
        .gb_a      (gb_a),
        .gb_wdata  (gb_wdata),
        .gb_wr     (gb_wr),
        .gb_rd     (gb_rd),
        .gb_cs     (gb_cs),
        .gb_rdata  (gb_rdata),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d,
                                input logic cs, input logic exp_req, input logic [21:0] exp_addr,
                                input logic [7:0] exp_rdata);
        vec_t v;
        v.op = op; v.a = a; v.d = d; v.cs = cs;
        v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    // One CPU access; the memory side acks after the request has been held 3 cycles.
    task automatic run_vec(input vec_t v, input string tag);
        logic saw;
        @(negedge clk);
        gb_a     = v.a;
        gb_cs    = v.cs;
        gb_wdata = v.d;
        gb_rd    = (v.op == OP_RD);
        gb_wr    = (v.op != OP_RD);
        if (v.op == OP_REG) begin
            @(negedge clk);
            chk({tag, "_reg_noreq"}, mem_req, 1'b0);
        end else begin
            saw = 1'b0;
            for (int n = 0; n < 4 && !saw; n++) begin
                @(negedge clk);
                saw = mem_req;
            end
            chk({tag, "_req"}, saw, v.exp_req);
            if (saw) begin
                if (v.exp_req) begin
                    chk({tag, "_addr"}, mem_addr, v.exp_addr);
                    chk({tag, "_we"}, mem_we, (v.op == OP_WR));
                    if (v.op == OP_WR)
                        chk({tag, "_wdata"}, mem_wdata, v.d);
                    repeat (2) @(negedge clk);
                    chk({tag, "_addr_hold"}, mem_addr, v.exp_addr);
                end
                mem_ack   = 1'b1;
                mem_rdata = (v.op == OP_RD) ? v.d : 8'h00;
                @(negedge clk);
                mem_ack   = 1'b0;
                mem_rdata = 8'h00;
                chk({tag, "_req_drop"}, mem_req, 1'b0);
            end
            if (v.op == OP_RD)
                chk({tag, "_rdata"}, gb_rdata, v.exp_rdata);
        end
        gb_rd = 1'b0;
        gb_wr = 1'b0;
        gb_cs = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; gb_a = 16'h0000; gb_wdata = 8'h00; gb_wr = 1'b0; gb_rd = 1'b0;
        gb_cs = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;

        vecs.push_back(mk(OP_RD,  16'h0150, 8'h3E, 1'b0, 1'b1, 22'h000150, 8'h3E));
        vecs.push_back(mk(OP_REG, 16'h2000, 8'h00, 1'b0, 1'b0, 22'h0,      8'h00));
        vecs.push_back(mk(OP_RD,  16'h4000, 8'h11, 1'b0, 1'b1, 22'h004000, 8'h11));
        vecs.push_back(mk(OP_REG, 16'h2000, 8'h1F, 1'b0, 1'b0, 22'h0,      8'h00));
        vecs.push_back(mk(OP_REG, 16'h4000, 8'h03, 1'b0, 1'b0, 22'h0,      8'h00));
        vecs.push_back(mk(OP_RD,  16'h4000, 8'h22, 1'b0, 1'b1, 22'h1FC000, 8'h22));
        vecs.push_back(mk(OP_RD,  16'h7FFF, 8'h23, 1'b0, 1'b1, 22'h1FFFFF, 8'h23));
        vecs.push_back(mk(OP_REG, 16'h6000, 8'h01, 1'b0, 1'b0, 22'h0,      8'h00));
        vecs.push_back(mk(OP_REG, 16'h4000, 8'h02, 1'b0, 1'b0, 22'h0,      8'h00));
        vecs.push_back(mk(OP_RD,  16'h0010, 8'h33, 1'b0, 1'b1, 22'h100010, 8'h33));
        vecs.push_back(mk(OP_REG, 16'h6000, 8'h00, 1'b0, 1'b0, 22'h0,      8'h00));
        vecs.push_back(mk(OP_RD,  16'h0010, 8'h44, 1'b0, 1'b1, 22'h000010, 8'h44));
        vecs.push_back(mk(OP_REG, 16'h2000, 8'h20, 1'b0, 1'b0, 22'h0,      8'h00));
        vecs.push_back(mk(OP_RD,  16'h4000, 8'h55, 1'b0, 1'b1, 22'h104000, 8'h55));
        vecs.push_back(mk(OP_RD,  16'hA123, 8'h00, 1'b1, 1'b0, 22'h0,      8'hFF));
        vecs.push_back(mk(OP_REG, 16'h0000, 8'h0A, 1'b0, 1'b0, 22'h0,      8'h00));
        vecs.push_back(mk(OP_REG, 16'h4000, 8'h01, 1'b0, 1'b0, 22'h0,      8'h00));
        vecs.push_back(mk(OP_REG, 16'h6000, 8'h01, 1'b0, 1'b0, 22'h0,      8'h00));
        vecs.push_back(mk(OP_WR,  16'hA123, 8'h55, 1'b1, 1'b1, 22'h202123, 8'h00));
        vecs.push_back(mk(OP_RD,  16'hA123, 8'h5A, 1'b1, 1'b1, 22'h202123, 8'h5A));
        vecs.push_back(mk(OP_RD,  16'hA123, 8'h00, 1'b0, 1'b0, 22'h0,      8'h5A));
        vecs.push_back(mk(OP_RD,  16'hC000, 8'h00, 1'b1, 1'b0, 22'h0,      8'h5A));
        vecs.push_back(mk(OP_REG, 16'h0000, 8'h0B, 1'b0, 1'b0, 22'h0,      8'h00));
        vecs.push_back(mk(OP_WR,  16'hA000, 8'h77, 1'b1, 1'b0, 22'h0,      8'h00));
        vecs.push_back(mk(OP_REG, 16'h0000, 8'h1A, 1'b0, 1'b0, 22'h0,      8'h00));
        vecs.push_back(mk(OP_RD,  16'hBFFF, 8'h66, 1'b1, 1'b1, 22'h203FFF, 8'h66));
        vecs.push_back(mk(OP_REG, 16'h6000, 8'h00, 1'b0, 1'b0, 22'h0,      8'h00));
        vecs.push_back(mk(OP_RD,  16'hBFFF, 8'h67, 1'b1, 1'b1, 22'h201FFF, 8'h67));

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req",   mem_req,   1'b0);
        chk("rst_busy",  busy,      1'b0);
        chk("rst_rdata", gb_rdata,  8'hFF);
        chk("rst_addr",  mem_addr,  22'h0);
        chk("rst_we",    mem_we,    1'b0);
        chk("rst_wdata", mem_wdata, 8'h00);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // Second read while the first is unacked: queued, issued right after the ack.
        @(negedge clk);
        gb_a = 16'h0150; gb_rd = 1'b1;
        @(negedge clk);
        chk("pend_req1",  mem_req,  1'b1);
        chk("pend_addr1", mem_addr, 22'h000150);
        gb_a = 16'h0200;
        @(negedge clk);
        chk("pend_busy1", busy,     1'b1);
        chk("pend_hold1", mem_addr, 22'h000150);
        mem_ack = 1'b1; mem_rdata = 8'hAA;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 8'h00;
        chk("pend_req2",   mem_req,  1'b1);
        chk("pend_addr2",  mem_addr, 22'h000200);
        chk("pend_busy2",  busy,     1'b1);
        chk("pend_rdata1", gb_rdata, 8'hAA);
        mem_ack = 1'b1; mem_rdata = 8'hBB;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 8'h00;
        chk("pend_req3",   mem_req,  1'b0);
        chk("pend_busy3",  busy,     1'b0);
        chk("pend_rdata2", gb_rdata, 8'hBB);
        gb_rd = 1'b0;
        @(negedge clk);

        // Bank write during an in-flight read: address held, write not queued.
        gb_a = 16'h4000; gb_rd = 1'b1;
        @(negedge clk);
        chk("bchg_addr0", mem_addr, 22'h084000);
        gb_rd = 1'b0; gb_wr = 1'b1; gb_a = 16'h2000; gb_wdata = 8'h05;
        @(negedge clk);
        chk("bchg_addr1", mem_addr, 22'h084000);
        chk("bchg_req1",  mem_req,  1'b1);
        gb_wr = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'h5C;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 8'h00;
        chk("bchg_busy",  busy,     1'b0);
        chk("bchg_rdata", gb_rdata, 8'h5C);
        run_vec(mk(OP_RD, 16'h4000, 8'h6D, 1'b0, 1'b1, 22'h094000, 8'h6D), "bchg_new");

        // Reset mid-access: port and registers clear without waiting for a clock.
        gb_a = 16'h4000; gb_rd = 1'b1;
        @(negedge clk);
        chk("rmid_req0", mem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rmid_req",   mem_req,  1'b0);
        chk("rmid_busy",  busy,     1'b0);
        chk("rmid_rdata", gb_rdata, 8'hFF);
        @(negedge clk);
        gb_rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_vec(mk(OP_RD,  16'h4000, 8'h5A, 1'b0, 1'b1, 22'h004000, 8'h5A), "post_bank");
        run_vec(mk(OP_RD,  16'hA000, 8'h00, 1'b1, 1'b0, 22'h0,      8'hFF), "post_ramen");
        run_vec(mk(OP_REG, 16'h4000, 8'h01, 1'b0, 1'b0, 22'h0,      8'h00), "post_b2");
        run_vec(mk(OP_RD,  16'h0010, 8'h12, 1'b0, 1'b1, 22'h000010, 8'h12), "post_mode");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
